// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int MEM_DEPTH  = 2**ADDR_W_DEF;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

    // The requester that did not just win.
    function automatic sel_e other_sel(input sel_e s);
        return (s == SEL_A) ? SEL_B : SEL_A;
    endfunction

endpackage

// File: rtl/mem_arbiter_2p_rr_arb2.sv
// Two-way round-robin picker. Pure combinational; the priority pointer
// register lives in the parent.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  sel_e ptr,
    output sel_e sel
);

    // Lone requester wins outright; on contention the pointer decides.
    always_comb begin
        sel = SEL_A;
        if (req_a && req_b) begin
            sel = ptr;
        end else if (req_b) begin
            sel = SEL_B;
        end
    end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Two-requester round-robin arbiter and access sequencer for a shared
// single-port memory. Optional macro MEM_INIT_EN adds a power-up pass that
// writes (2*k) mod 2**DATA_W to every address k before requests are served.
//
// state  | meaning
// -------+------------------------------------------------------------
// INIT   | pattern fill, one write per cycle (MEM_INIT_EN builds only)
// IDLE   | waiting for a request; grant issued on the way out
// ACCESS | memory cycle in flight; read data captured on the way out
module mem_arbiter_2p
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              init_done,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            state_q, state_d;
    sel_e              ptr_q, ptr_d;
    sel_e              owner_q, owner_d;
    sel_e              pick;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;

`ifdef MEM_INIT_EN
    localparam state_e RST_STATE = INIT;
    logic              init_done_q, init_done_d;
    logic [ADDR_W-1:0] init_addr;

    // The address register doubles as the fill counter: restart at 0 when
    // no write is in flight, otherwise step past the address just written.
    assign init_addr = mem_cs_q ? (mem_addr_q + ADDR_W'(1)) : '0;
    assign init_done = init_done_q;
`else
    localparam state_e RST_STATE = IDLE;
    assign init_done = 1'b1;
`endif

    rr_arb2 u_rr_arb2 (
        .req_a (req_a),
        .req_b (req_b),
        .ptr   (ptr_q),
        .sel   (pick)
    );

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        mem_cs_d   = mem_cs_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
`ifdef MEM_INIT_EN
        init_done_d = init_done_q;
`endif
        case (state_q)
`ifdef MEM_INIT_EN
            INIT: begin
                if (mem_cs_q && (mem_addr_q == '1)) begin
                    mem_cs_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    mem_cs_d   = 1'b1;
                    mem_wr_d   = 1'b1;
                    mem_addr_d = init_addr;
                    mem_din_d  = DATA_W'({init_addr, 1'b0});
                end
            end
`endif
            IDLE: begin
                if (req_a || req_b) begin
                    owner_d  = pick;
                    ptr_d    = other_sel(pick);
                    mem_cs_d = 1'b1;
                    state_d  = ACCESS;
                    if (pick == SEL_B) begin
                        gnt_b_d    = 1'b1;
                        mem_wr_d   = we_b;
                        mem_addr_d = addr_b;
                        mem_din_d  = wdata_b;
                    end else begin
                        gnt_a_d    = 1'b1;
                        mem_wr_d   = we_a;
                        mem_addr_d = addr_a;
                        mem_din_d  = wdata_a;
                    end
                end
            end
            ACCESS: begin
                mem_cs_d = 1'b0;
                mem_wr_d = 1'b0;
                state_d  = IDLE;
                if (!mem_wr_q) begin
                    if (owner_q == SEL_B) begin
                        rvalid_b_d = 1'b1;
                        rdata_b_d  = mem_dout;
                    end else begin
                        rvalid_a_d = 1'b1;
                        rdata_a_d  = mem_dout;
                    end
                end
            end
            default: begin
                mem_cs_d = 1'b0;
                mem_wr_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops chip select immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            ptr_q      <= SEL_A;
            owner_q    <= SEL_A;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            mem_cs_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
`ifdef MEM_INIT_EN
            init_done_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            mem_cs_q   <= mem_cs_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
`ifdef MEM_INIT_EN
            init_done_q <= init_done_d;
`endif
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign mem_cs   = mem_cs_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Bench for mem_arbiter_2p with a behavioural 1024x8 memory attached.
module tb_mem_arbiter_2p;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;

`ifdef MEM_INIT_EN
    localparam bit EXP_INIT_DONE_RST = 1'b0;
`else
    localparam bit EXP_INIT_DONE_RST = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a, req_b, we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          init_done, mem_cs, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] shadow [DEPTH];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .we_a      (we_a),
        .we_b      (we_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .wdata_a   (wdata_a),
        .wdata_b   (wdata_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .rvalid_a  (rvalid_a),
        .rvalid_b  (rvalid_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .init_done (init_done),
        .mem_cs    (mem_cs),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always @(posedge clk) begin
        if (mem_cs && mem_wr) mem[mem_addr] <= mem_din;
    end
    assign mem_dout = mem[mem_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a] <= v;
        #1;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 1100 && !init_done; i++) tick();
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done_timeout: got %b want 1", init_done);
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        wait_init();
    endtask

    // Drive one request, wait (bounded) for the grant, then report the result.
    task automatic do_access(input bit port_b, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output bit got_gnt,
                             output bit got_rv, output logic [DW-1:0] rd);
        if (port_b) begin req_b = 1; we_b = we; addr_b = a; wdata_b = d; end
        else        begin req_a = 1; we_a = we; addr_a = a; wdata_a = d; end
        got_gnt = 0;
        for (int i = 0; i < 8 && !got_gnt; i++) begin
            tick();
            got_gnt = port_b ? gnt_b : gnt_a;
        end
        idle_inputs();
        tick();
        got_rv = port_b ? rvalid_b : rvalid_a;
        rd     = port_b ? rdata_b : rdata_a;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        checks++;
        if ({gnt_a, gnt_b, rvalid_a, rvalid_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 0000", {gnt_a, gnt_b, rvalid_a, rvalid_b});
        end
        checks++;
        if ({mem_cs, mem_wr} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mem_ctl: got %b want 00", {mem_cs, mem_wr});
        end
        checks++;
        if ({rdata_a, rdata_b, mem_addr, mem_din} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata_a=%h rdata_b=%h addr=%h din=%h want 0",
                     rdata_a, rdata_b, mem_addr, mem_din);
        end
        checks++;
        if (init_done !== EXP_INIT_DONE_RST) begin
            errors++;
            $display("FAIL reset_init_done: got %b want %b", init_done, EXP_INIT_DONE_RST);
        end
        tick();
        rst_n = 1;
        wait_init();
    endtask

    task automatic test_write_read_a();
        req_a = 1; we_a = 1; addr_a = 10'd5; wdata_a = 8'h3C;
        tick();
        checks++;
        if ({gnt_a, gnt_b, mem_cs, mem_wr} !== 4'b1011 || mem_addr !== 10'd5 || mem_din !== 8'h3C) begin
            errors++;
            $display("FAIL wr_grant: gnt_a=%b gnt_b=%b cs=%b wr=%b addr=%0d din=%h want 1 0 1 1 5 3c",
                     gnt_a, gnt_b, mem_cs, mem_wr, mem_addr, mem_din);
        end
        idle_inputs();
        tick();
        checks++;
        if ({gnt_a, mem_cs, mem_wr, rvalid_a} !== 4'b0000) begin
            errors++;
            $display("FAIL wr_done: gnt_a=%b cs=%b wr=%b rvalid_a=%b want 0000",
                     gnt_a, mem_cs, mem_wr, rvalid_a);
        end
        req_a = 1; we_a = 0; addr_a = 10'd5;
        tick();
        checks++;
        if ({gnt_a, mem_cs, mem_wr, rvalid_a} !== 4'b1100) begin
            errors++;
            $display("FAIL rd_grant: gnt_a=%b cs=%b wr=%b rvalid_a=%b want 1100",
                     gnt_a, mem_cs, mem_wr, rvalid_a);
        end
        idle_inputs();
        tick();
        checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== 8'h3C || gnt_a !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: rvalid_a=%b rdata_a=%h gnt_a=%b want 1 3c 0", rvalid_a, rdata_a, gnt_a);
        end
        tick();
        checks++;
        if (rvalid_a !== 1'b0 || rdata_a !== 8'h3C) begin
            errors++;
            $display("FAIL rd_hold: rvalid_a=%b rdata_a=%h want 0 3c", rvalid_a, rdata_a);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        preload(10'd10, 8'hAA);
        preload(10'd20, 8'h55);
        req_a = 1; we_a = 0; addr_a = 10'd10;
        req_b = 1; we_b = 0; addr_b = 10'd20;
        for (int c = 1; c <= 8; c++) begin
            logic [3:0] exp_v;
            tick();
            // cycle 1,5 grant A; 3,7 grant B; following cycle returns its data
            case (c % 4)
                1: exp_v = 4'b1000;
                2: exp_v = 4'b0010;
                3: exp_v = 4'b0100;
                default: exp_v = 4'b0001;
            endcase
            checks++;
            if ({gnt_a, gnt_b, rvalid_a, rvalid_b} !== exp_v) begin
                errors++;
                $display("FAIL contention_c%0d: gnt_a,gnt_b,rv_a,rv_b=%b want %b",
                         c, {gnt_a, gnt_b, rvalid_a, rvalid_b}, exp_v);
            end
            if (exp_v[1]) begin
                checks++;
                if (rdata_a !== 8'hAA) begin
                    errors++;
                    $display("FAIL contention_rdata_a: got %h want aa", rdata_a);
                end
            end
            if (exp_v[0]) begin
                checks++;
                if (rdata_b !== 8'h55) begin
                    errors++;
                    $display("FAIL contention_rdata_b: got %h want 55", rdata_b);
                end
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_boundary();
        bit g, v;
        logic [DW-1:0] rd;
        do_access(1'b1, 1'b1, 10'd1023, 8'hFF, g, v, rd);
        checks++;
        if (g !== 1'b1 || v !== 1'b0) begin
            errors++;
            $display("FAIL bnd_wr_hi: gnt=%b rvalid=%b want 1 0", g, v);
        end
        do_access(1'b1, 1'b1, 10'd0, 8'h01, g, v, rd);
        checks++;
        if (g !== 1'b1 || v !== 1'b0) begin
            errors++;
            $display("FAIL bnd_wr_lo: gnt=%b rvalid=%b want 1 0", g, v);
        end
        do_access(1'b1, 1'b0, 10'd1023, 8'h00, g, v, rd);
        checks++;
        if (g !== 1'b1 || v !== 1'b1 || rd !== 8'hFF) begin
            errors++;
            $display("FAIL bnd_rd_hi: gnt=%b rvalid=%b rdata=%h want 1 1 ff", g, v, rd);
        end
        do_access(1'b1, 1'b0, 10'd0, 8'h00, g, v, rd);
        checks++;
        if (g !== 1'b1 || v !== 1'b1 || rd !== 8'h01) begin
            errors++;
            $display("FAIL bnd_rd_lo: gnt=%b rvalid=%b rdata=%h want 1 1 01", g, v, rd);
        end
    endtask

    task automatic test_reset_mid_access();
        bit g, v;
        logic [DW-1:0] rd;
        logic [DW-1:0] exp_rd;
`ifdef MEM_INIT_EN
        exp_rd = 8'd20;
`else
        exp_rd = 8'hAA;
`endif
        req_a = 1; we_a = 0; addr_a = 10'd10;
        tick();
        checks++;
        if (gnt_a !== 1'b1 || mem_cs !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant: gnt_a=%b cs=%b want 1 1", gnt_a, mem_cs);
        end
        idle_inputs();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({mem_cs, mem_wr} !== 2'b00) begin
            errors++;
            $display("FAIL mid_cs_drop: cs,wr=%b want 00", {mem_cs, mem_wr});
        end
        tick();
        rst_n = 1;
        checks++;
        if (rvalid_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_rvalid: got %b want 0", rvalid_a);
        end
        tick();
        checks++;
        if (rvalid_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_rvalid_after: got %b want 0", rvalid_a);
        end
        wait_init();
        do_access(1'b0, 1'b0, 10'd10, 8'h00, g, v, rd);
        checks++;
        if (g !== 1'b1 || v !== 1'b1 || rd !== exp_rd) begin
            errors++;
            $display("FAIL mid_fresh_read: gnt=%b rvalid=%b rdata=%h want 1 1 %h", g, v, rd, exp_rd);
        end
    endtask

`ifdef MEM_INIT_EN
    task automatic test_init_fill();
        int cyc;
        int early_gnt;
        bit g, v;
        logic [DW-1:0] rd;
        idle_inputs();
        rst_n = 0;
        tick();
        req_a = 1; we_a = 0; addr_a = 10'd100;
        rst_n = 1;
        cyc = 0;
        early_gnt = 0;
        while (!init_done && cyc < 1100) begin
            tick();
            cyc++;
            if (gnt_a && !init_done) early_gnt++;
        end
        checks++;
        if (early_gnt != 0 || cyc < 1024 || cyc > 1025) begin
            errors++;
            $display("FAIL init_window: early_gnt=%0d cycles=%0d want 0 and 1024..1025", early_gnt, cyc);
        end
        g = 0;
        for (int i = 0; i < 4 && !g; i++) begin
            tick();
            g = gnt_a;
        end
        idle_inputs();
        tick();
        checks++;
        if (g !== 1'b1 || rvalid_a !== 1'b1 || rdata_a !== 8'd200) begin
            errors++;
            $display("FAIL init_rd_100: gnt=%b rvalid=%b rdata=%0d want 1 1 200", g, rvalid_a, rdata_a);
        end
        do_access(1'b0, 1'b0, 10'd200, 8'h00, g, v, rd);
        checks++;
        if (g !== 1'b1 || v !== 1'b1 || rd !== 8'd144) begin
            errors++;
            $display("FAIL init_rd_200: gnt=%b rvalid=%b rdata=%0d want 1 1 144", g, v, rd);
        end
        do_access(1'b1, 1'b0, 10'd1023, 8'h00, g, v, rd);
        checks++;
        if (g !== 1'b1 || v !== 1'b1 || rd !== 8'd254) begin
            errors++;
            $display("FAIL init_rd_1023: gnt=%b rvalid=%b rdata=%0d want 1 1 254", g, v, rd);
        end
    endtask
`endif

    // Random traffic against a transaction-level model: a free arbiter serves
    // a lone requester, alternates on contention (A first after reset), and is
    // busy for exactly one cycle after each grant.
    task automatic test_random();
        bit pend_a = 0, pend_b = 0, cool_a = 0, cool_b = 0;
        bit r_we_a = 0, r_we_b = 0;
        logic [AW-1:0] r_ad_a = '0, r_ad_b = '0;
        logic [DW-1:0] r_wd_a = '0, r_wd_b = '0;
        bit m_busy = 0, m_turn_b = 0, m_b = 0, m_we = 0;
        logic [AW-1:0] m_addr = '0;
        logic [DW-1:0] e_ra = '0, e_rb = '0;
        bit e_ga, e_gb, e_va, e_vb, win_b;
        int bad = 0;

        apply_reset();
        for (int i = 0; i < DEPTH; i++) shadow[i] = mem[i];

        for (int c = 0; c < 400; c++) begin
            if (!pend_a && !cool_a && $urandom_range(0, 1) == 1) begin
                pend_a = 1; r_we_a = 1'($urandom_range(0, 1));
                r_ad_a = ($urandom_range(0, 4) == 0) ? 10'd1023 : AW'($urandom_range(0, 7));
                r_wd_a = DW'($urandom);
            end
            if (!pend_b && !cool_b && $urandom_range(0, 1) == 1) begin
                pend_b = 1; r_we_b = 1'($urandom_range(0, 1));
                r_ad_b = ($urandom_range(0, 4) == 0) ? 10'd1023 : AW'($urandom_range(0, 7));
                r_wd_b = DW'($urandom);
            end
            cool_a = 0; cool_b = 0;
            req_a = pend_a; we_a = r_we_a; addr_a = r_ad_a; wdata_a = r_wd_a;
            req_b = pend_b; we_b = r_we_b; addr_b = r_ad_b; wdata_b = r_wd_b;

            e_ga = 0; e_gb = 0; e_va = 0; e_vb = 0;
            if (m_busy) begin
                m_busy = 0;
                if (!m_we) begin
                    if (m_b) begin e_vb = 1; e_rb = shadow[m_addr]; end
                    else     begin e_va = 1; e_ra = shadow[m_addr]; end
                end
            end else if (pend_a || pend_b) begin
                win_b    = (pend_a && pend_b) ? m_turn_b : pend_b;
                m_turn_b = !win_b;
                m_busy   = 1;
                m_b      = win_b;
                m_we     = win_b ? r_we_b : r_we_a;
                m_addr   = win_b ? r_ad_b : r_ad_a;
                if (m_we) shadow[m_addr] = win_b ? r_wd_b : r_wd_a;
                if (win_b) e_gb = 1; else e_ga = 1;
            end

            tick();
            checks++;
            if ({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_cs} !== {e_ga, e_gb, e_va, e_vb, m_busy}
                || rdata_a !== e_ra || rdata_b !== e_rb
                || (m_busy && (mem_wr !== m_we || mem_addr !== m_addr))) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_c%0d: ga gb va vb cs=%b%b%b%b%b rda=%h rdb=%h wr=%b addr=%0d want %b%b%b%b%b %h %h %b %0d",
                             c, gnt_a, gnt_b, rvalid_a, rvalid_b, mem_cs, rdata_a, rdata_b, mem_wr, mem_addr,
                             e_ga, e_gb, e_va, e_vb, m_busy, e_ra, e_rb, m_we, m_addr);
                bad++;
            end
            if (e_ga) begin pend_a = 0; cool_a = 1; end
            if (e_gb) begin pend_b = 0; cool_b = 1; end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        idle_inputs();
        test_reset();
        test_write_read_a();
        test_contention();
        test_boundary();
        test_reset_mid_access();
`ifdef MEM_INIT_EN
        test_init_fill();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2p.md
Name: mem_arbiter_2p

Overview:
Two-requester round-robin arbiter and access sequencer for the shared 1024x8 single-port memory (ports data_in, data_out, addr, wr, cs).
- Converts per-requester req/gnt handshakes into timed memory cycles.
- Drives the memory control and address lines from registers.
- Captures read data and returns it with a valid pulse.
- Sits between two bus masters and the memory instance.

Parameters:
- ADDR_W, 10, memory address width (depth = 2**ADDR_W).
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a, req_b  input  1  access request per requester.
- we_a, we_b  input  1  1 = write, 0 = read.
- addr_a, addr_b  input  ADDR_W  request address.
- wdata_a, wdata_b  input  DATA_W  write data.
- gnt_a, gnt_b  output  1  one-cycle grant pulse; the request is latched.
- rvalid_a, rvalid_b  output  1  one-cycle read-data-valid pulse.
- rdata_a, rdata_b  output  DATA_W  read data, held until the next read for that port.
- init_done  output  1  controller ready to accept requests.
- mem_cs  output  1  memory chip select.
- mem_wr  output  1  memory write enable (write when mem_cs=1 and mem_wr=1).
- mem_addr  output  ADDR_W  memory address.
- mem_din  output  DATA_W  memory write data.
- mem_dout  input  DATA_W  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async, rst_n=0): all gnt, rvalid, rdata, mem_cs, mem_wr, mem_addr and mem_din = 0. State = IDLE (INIT if the feature is enabled). Priority pointer = A. init_done = 1 without MEM_INIT_EN, 0 with it.
- Reset mid-access: mem_cs and mem_wr drop immediately (asynchronously). No rvalid is issued for the aborted access.
- States: IDLE, ACCESS, plus INIT with the feature enabled.
- IDLE: if any req is high, the winner is chosen as follows:
  - only one req high: that requester wins;
  - both high: the requester indicated by the priority pointer wins.
- At the next edge after a win:
  - gnt_x = 1 for one cycle;
  - mem_addr, mem_din and mem_wr are loaded from the winner; mem_cs = 1;
  - the priority pointer moves to the other requester;
  - state = ACCESS.
- ACCESS (exactly 1 cycle). At the next edge:
  - mem_cs = 0 and mem_wr = 0; state = IDLE;
  - for a read: rdata_x <= mem_dout and rvalid_x = 1 for one cycle.
- Latency:
  - req sampled in cycle N -> gnt at edge N+1;
  - read data valid at edge N+2.
- Throughput: one access every 2 cycles. With continuous contention, grants alternate A, B, A, B.
- Handshake:
  - requester holds req, we, addr and wdata stable until it sees gnt;
  - requester drops req in the cycle after gnt;
  - req still high in IDLE after the gnt cycle is a new request.
- No grant in ACCESS; requests simply wait.
- mem_addr and mem_din hold their last values while idle.
- Address is used as given; no wrap logic is needed. 0 and 2**ADDR_W-1 are both legal.

Optional Feature:
- Macro: MEM_INIT_EN.
- Defined: after reset release, state INIT writes a pattern to every address k = 0..2**ADDR_W-1:
  - one write per cycle (mem_cs=1, mem_wr=1, mem_addr=k);
  - mem_din = (2*k) mod 2**DATA_W.
- After the last write (at edge 1024 for the default parameters): mem_cs = 0, init_done = 1, state = IDLE.
- Requests arriving during INIT are not granted; they stay pending.
- Not defined: no INIT state. init_done is a constant 1 and the controller starts in IDLE.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state enum (INIT, IDLE, ACCESS);
  - default ADDR_W and DATA_W;
  - MEM_DEPTH = 2**ADDR_W.
- Sub-module rr_arb2: two-way round-robin picker.
  - Inputs: req_a, req_b, ptr. Output: sel.
  - Combinational pick; the pointer register stays in the parent.

Test Plan:
1. Reset: hold rst_n=0 -> gnt, rvalid and mem_cs = 0, rdata = 0. init_done = 1 without MEM_INIT_EN.
2. Write then read on A: write addr 5, data 0x3C; then read addr 5.
   - gnt_a one cycle after req; mem_cs=1 and mem_wr=1 for one cycle on the write;
   - on the read, rvalid_a at req+2 with rdata_a = 0x3C.
3. Both requests after reset, held continuously, reading addrs 10 and 20 preloaded with 0xAA and 0x55:
   - grants A, B, A, B every 2 cycles;
   - rdata_a = 0xAA, rdata_b = 0x55.
4. Boundary addresses: B writes 0xFF to addr 1023 and 0x01 to addr 0, then reads both -> 0xFF and 0x01, with no aliasing.
5. Reset mid-access: drive rst_n=0 during ACCESS of a read on A.
   - mem_cs = 0 immediately; no rvalid_a;
   - after release, a fresh req_a is granted normally.
6. With MEM_INIT_EN: req_a asserted during INIT.
   - No gnt until init_done = 1 (1024 cycles after reset release).
   - Reads of addr 100 -> 200; addr 200 -> 144; addr 1023 -> 254.
